cv32e41p_obi_mem_responder: RTL and testbench
=============================================

# cv32e41p_obi_mem_responder

Behavioural OBI responder that terminates the instruction or data memory interface of a cv32e41p core in simulation benches. It grants requests, applies byte-enabled writes to an internal word array, and returns in-order read/write responses after a fixed latency. It supports multiple outstanding transactions. One instance sits on each core memory port in the bench top-level.

## Interface
- ADDR_WIDTH, 16: byte-address bits decoded; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
- LATENCY, 1: cycles from grant edge to rvalid_o; legal range 1..8.
- MAX_OUTSTANDING, 2: response FIFO depth; legal range 1..8.
- STALL_SEED, 16'hACE1: LFSR seed, used only with the stall macro; must be non-zero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data; 0 for write responses.

## Operation
- Word index is addr_i[ADDR_WIDTH-1:2]. Upper bits are ignored, so addresses alias. addr_i[1:0] is ignored.
- gnt_o = rst_ni && req_i && !stall && (count < MAX_OUTSTANDING || rvalid_o).
  - A pop in the same cycle frees a slot.
- Transaction accepted on clock edge where req_i && gnt_o.
  - Write: each byte of mem[idx] with be_i[b]=1 takes wdata_i[8b+7:8b] at that edge.
  - Read: rdata is sampled from mem[idx] at that edge, prior to any same-edge write. Only one transaction is accepted per edge.
- Each accepted transaction pushes entry {rdata, due}. due = ts + LATENCY, modulo 2^TS_W, where TS_W = 4.
  - ts is a free-running TS_W-bit counter, reset 0.
- Responses are strictly in order, at most one per cycle. rvalid_o is asserted in the cycle where the head entry is valid and head.due == ts.
  - The head is popped at the end of that cycle.
- Accepts are at most one per cycle and each due is distinct, so the head is never overdue.
- count tracks accepted minus popped entries. Simultaneous push and pop leaves count unchanged.
- Memory is not reset. Contents persist across rst_ni assertion. Benches preload it via hierarchical write to mem.

## Timing
- Reset values: rvalid_o=0, rdata_o=0, count=0, ts=0, FIFO empty. gnt_o=0 while rst_ni=0.
- Reset mid-operation: all pending responses are dropped. No rvalid_o is issued for transactions accepted before reset.
- gnt_o is combinational from req_i and state. gnt_o may rise in the same cycle as req_i.
- rvalid_o and rdata_o are registered. Outside rvalid_o, rdata_o = 0.
- Read latency is exactly LATENCY cycles from the accept edge to the rvalid_o cycle.
- Full throughput of one accept per cycle requires MAX_OUTSTANDING >= LATENCY. Otherwise gnt_o drops while the FIFO is full without a pop.
- Read-after-write: a read accepted one edge after a write to the same word returns the written data.

## Configuration
- CV32E41P_OBI_MEM_RAND_STALL_EN defined: instantiate a 16-bit Fibonacci LFSR.
  - Taps 16,14,13,11; reset to STALL_SEED; advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving roughly 25% grant withholding. Latency is unaffected.
- Not defined: stall = 0 and no LFSR logic is present.

## Structure
- Package cv32e41p_obi_mem_pkg holds:
  - typedef obi_resp_entry_t {logic [31:0] rdata; logic [3:0] due;}
  - localparam TS_W = 4
  - LFSR tap mask constant 16'hB400
- Sub-module cv32e41p_obi_resp_fifo: parameterised-depth circular FIFO of obi_resp_entry_t.
  - Ports: push, pop, full, empty, head.
  - Pointer wrap is handled via an extra MSB bit.

## Test plan
- Preload mem[4]=32'hDEADBEEF; LATENCY=1; read addr 32'h10 -> gnt_o same cycle, then rvalid_o one cycle later with rdata_o=32'hDEADBEEF.
- Write 32'h11223344 be=4'b0101 to addr 32'h20 over mem[8]=32'hFFFFFFFF; read back next cycle -> 32'hFF22FF44; the write response has rdata_o=0.
- LATENCY=3, MAX_OUTSTANDING=3; four back-to-back reads of words 0..3 -> gnt_o high every cycle; rvalid_o on four consecutive cycles starting 3 cycles after the first accept; data in order.
- LATENCY=3, MAX_OUTSTANDING=1; continuous req_i -> gnt_o high once every 3 cycles; count never exceeds 1.
- Assert rst_ni low with 2 reads pending -> no rvalid_o afterwards; outputs 0; memory contents unchanged after reset release.
- With CV32E41P_OBI_MEM_RAND_STALL_EN and 1000 cycles of req_i -> gnt_o low on 20–30% of cycles; every accept is answered exactly LATENCY cycles later.

Source files
------------

// File: rtl/cv32e41p_obi_mem_pkg.sv
// Shared types and constants for the OBI memory responder: response entry, timestamp width, stall LFSR.
package cv32e41p_obi_mem_pkg;

  localparam int TS_W = 4;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [31:0]     rdata;
    logic [TS_W-1:0] due;
  } obi_resp_entry_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cv32e41p_obi_resp_fifo.sv
// In-order response queue, DEPTH entries; head/head_next readable combinationally, push visible next cycle.
// No internal backpressure: the caller must not push while full unless it pops in the same cycle.
module cv32e41p_obi_resp_fifo
  import cv32e41p_obi_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  obi_resp_entry_t push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output obi_resp_entry_t head,
  output obi_resp_entry_t head_next
);

  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  obi_resp_entry_t slots [SLOTS];
  logic [IW:0]     wr_ptr;
  logic [IW:0]     rd_ptr;
  logic [IW:0]     rd_ptr_inc;

  // Index wraps at DEPTH-1 and toggles the extra MSB, so non-power-of-two depths work
  function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      return {~p[IW], {IW{1'b0}}};
    end
    return {p[IW], p[IW-1:0] + IW'(1)};
  endfunction

  assign rd_ptr_inc = ptr_inc(rd_ptr);
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign head       = slots[rd_ptr[IW-1:0]];
  assign head_next  = slots[rd_ptr_inc[IW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_ptr_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) slots[wr_ptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cv32e41p_obi_mem_responder.sv
// Simulation OBI memory: LATENCY cycles grant-edge to rvalid, in-order, up to MAX_OUTSTANDING pending;
// gnt_o drops when the queue is full without a pop, or on LFSR stalls when CV32E41P_OBI_MEM_RAND_STALL_EN is defined.
module cv32e41p_obi_mem_responder
  import cv32e41p_obi_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 16,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int              WORDS  = 1 << (ADDR_WIDTH - 2);
  localparam int              CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TS_W-1:0] LAT_TS = TS_W'(LATENCY);

  logic [31:0]           mem [WORDS];
  logic [ADDR_WIDTH-3:0] idx;
  logic [TS_W-1:0]       ts;
  logic [TS_W-1:0]       ts_inc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_n;
  logic                  stall;
  logic                  accept;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rvalid_d;
  logic                  unused_addr;
  obi_resp_entry_t       push_entry;
  obi_resp_entry_t       head;
  obi_resp_entry_t       head_next;
  obi_resp_entry_t       next_head;

  assign idx         = addr_i[ADDR_WIDTH-1:2];
  assign unused_addr = ^addr_i;
  assign ts_inc      = ts + TS_W'(1);

`ifdef CV32E41P_OBI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= STALL_SEED;
    else         lfsr <= lfsr_next(lfsr);
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A pop this cycle frees a slot, so a full queue can still take a request
  assign gnt_o  = rst_ni && req_i && !stall && (!fifo_full || rvalid_o);
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o;

  assign push_entry.rdata = we_i ? 32'h0 : mem[idx];
  assign push_entry.due   = ts + LAT_TS;

  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  cv32e41p_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .head_next (head_next)
  );

  assign count_n = count + CW'(accept) - CW'(pop);

  // Head as it will stand after this edge; lets rvalid_o/rdata_o be plain flops
  always_comb begin
    next_head = push_entry;
    if (pop) begin
      if (count > CW'(1)) next_head = head_next;
    end else if (!fifo_empty) begin
      next_head = head;
    end
  end

  assign rvalid_d = (count_n != '0) && (next_head.due == ts_inc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts       <= '0;
      count    <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      ts       <= ts_inc;
      count    <= count_n;
      rvalid_o <= rvalid_d;
      rdata_o  <= rvalid_d ? next_head.rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_cv32e41p_obi_mem_responder.sv
// Scoreboard bench: three responder instances (L1/M2, L3/M3, L3/M1) driven by directed transactions.
`timescale 1ns/1ps
module tb_cv32e41p_obi_mem_responder;

  localparam int N = 3;
  localparam int LAT_T [N] = '{1, 3, 3};
  localparam int MO_T  [N] = '{2, 3, 1};

  typedef struct {
    logic [31:0] d;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [N];
  logic        gnt    [N];
  logic        we     [N];
  logic        rvalid [N];
  logic [3:0]  be     [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [31:0] rdata  [N];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : gen_dut
    cv32e41p_obi_mem_responder #(
      .ADDR_WIDTH      (16),
      .LATENCY         (LAT_T[g]),
      .MAX_OUTSTANDING (MO_T[g]),
      .STALL_SEED      (16'hACE1)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req[g]),
      .gnt_o    (gnt[g]),
      .addr_i   (addr[g]),
      .we_i     (we[g]),
      .be_i     (be[g]),
      .wdata_i  (wdata[g]),
      .rvalid_o (rvalid[g]),
      .rdata_o  (rdata[g])
    );
  end

  task automatic push_exp(input int g, input logic [31:0] d, input int at);
    exp_t e;
    e.d  = d;
    e.at = at;
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int g);
    case (g)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int q_front_at(input int g);
    case (g)
      0:       return q0[0].at;
      1:       return q1[0].at;
      default: return q2[0].at;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req_v);
    end
  endtask

  // Monitor: every response must match the oldest expectation in data and cycle
  task automatic check_port(input int g);
    exp_t e;
    if (rvalid[g]) begin
      checks++;
      if (q_size(g) == 0) begin
        errors++;
        $display("FAIL rsp%0d_unexpected: rvalid with data %h at cycle %0d, none expected", g, rdata[g], cyc);
      end else begin
        e = q_pop(g);
        if (rdata[g] !== e.d || cyc != e.at) begin
          errors++;
          $display("FAIL rsp%0d_data: got %h at cycle %0d, expected %h at cycle %0d",
                   g, rdata[g], cyc, e.d, e.at);
        end
      end
    end else begin
      checks++;
      if (rdata[g] !== 32'h0) begin
        errors++;
        $display("FAIL rsp%0d_idle_rdata: got %h without rvalid, expected 0", g, rdata[g]);
      end
      if (q_size(g) != 0 && q_front_at(g) <= cyc) begin
        checks++;
        errors++;
        e = q_pop(g);
        $display("FAIL rsp%0d_missing: no rvalid at cycle %0d, expected data %h", g, cyc, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < N; g++) check_port(g);
    end
  end

  // Hold req until granted (bounded), log the expected response; returns at posedge+1
  task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [31:0] ed,
                       output int waits, output int gcyc);
    waits = 0;
    gcyc  = -1;
    req[g] = 1'b1; we[g] = w; addr[g] = a; be[g] = b; wdata[g] = wd;
    forever begin
      @(negedge clk);
      if (gnt[g]) break;
      waits++;
      if (waits > 40) break;
    end
    if (gnt[g]) begin
      gcyc = cyc;
      push_exp(g, ed, cyc + LAT_T[g]);
    end else begin
      checks++;
      errors++;
      $display("FAIL grant_timeout%0d: no gnt after %0d cycles, expected a grant", g, waits);
    end
    @(posedge clk); #1;
    req[g] = 1'b0; we[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, c, prev;
    for (int g = 0; g < N; g++) begin
      req[g] = 1'b1; we[g] = 1'b0; be[g] = 4'h0; addr[g] = '0; wdata[g] = '0;
    end
    gen_dut[0].u_dut.mem[4] = 32'hDEADBEEF;
    gen_dut[0].u_dut.mem[8] = 32'hFFFFFFFF;
    gen_dut[0].u_dut.mem[9] = 32'h12345678;
    gen_dut[1].u_dut.mem[0] = 32'h10000000;
    gen_dut[1].u_dut.mem[1] = 32'h21111111;
    gen_dut[1].u_dut.mem[2] = 32'h32222222;
    gen_dut[1].u_dut.mem[3] = 32'h43333333;
    gen_dut[2].u_dut.mem[5] = 32'h55AA0005;

    // Reset state with req held high
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check_eq($sformatf("reset_gnt%0d", g), {31'b0, gnt[g]}, 32'h0);
      check_eq($sformatf("reset_rvalid%0d", g), {31'b0, rvalid[g]}, 32'h0);
      check_eq($sformatf("reset_rdata%0d", g), rdata[g], 32'h0);
    end
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) req[g] = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Single read, LATENCY 1
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, w, c);
`ifndef CV32E41P_OBI_MEM_RAND_STALL_EN
    check_eq("t1_gnt_same_cycle", w, 0);
`endif
    idle(3);

    // Byte-enabled writes, read-after-write, aliasing
    issue(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, 32'h0, w, c);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hFF22FF44, w, c);
    issue(0, 1'b0, 32'hFFFF0023, 4'hF, 32'h0, 32'hFF22FF44, w, c);
    issue(0, 1'b1, 32'h24, 4'b0000, 32'hCAFEF00D, 32'h0, w, c);
    issue(0, 1'b0, 32'h24, 4'hF, 32'h0, 32'h12345678, w, c);
    issue(0, 1'b1, 32'h26, 4'b1010, 32'hAABBCCDD, 32'h0, w, c);
    issue(0, 1'b0, 32'h24, 4'hF, 32'h0, 32'hAA34CC78, w, c);
    issue(0, 1'b1, 32'h24, 4'b1111, 32'h0BADC0DE, 32'h0, w, c);
    issue(0, 1'b0, 32'h24, 4'hF, 32'h0, 32'h0BADC0DE, w, c);
    idle(4);

    // Back-to-back reads, LATENCY 3, 3 outstanding
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ed_tab [4];
      ed_tab = '{32'h10000000, 32'h21111111, 32'h32222222, 32'h43333333};
      issue(1, 1'b0, 32'(i * 4), 4'hF, 32'h0, ed_tab[i], w, c);
`ifndef CV32E41P_OBI_MEM_RAND_STALL_EN
      check_eq($sformatf("t3_gnt_every_cycle%0d", i), w, 0);
`endif
    end
    idle(6);

    // Continuous requests, LATENCY 3, single outstanding
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      issue(2, 1'b0, 32'h14, 4'hF, 32'h0, 32'h55AA0005, w, c);
`ifndef CV32E41P_OBI_MEM_RAND_STALL_EN
      if (i > 0) begin
        check_eq($sformatf("t4_gnt_interval%0d", i), c - prev, 3);
        check_eq($sformatf("t4_gnt_wait%0d", i), w, 2);
      end
`endif
      prev = c;
    end
    idle(6);

    // Reset with two reads pending
    issue(1, 1'b0, 32'h0, 4'hF, 32'h0, 32'h10000000, w, c);
    issue(1, 1'b0, 32'h4, 4'hF, 32'h0, 32'h21111111, w, c);
    rst_n = 1'b0;
    q1.delete();
    req[1] = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_gnt", {31'b0, gnt[1]}, 32'h0);
    check_eq("rst_mid_rvalid", {31'b0, rvalid[1]}, 32'h0);
    check_eq("rst_mid_rdata", rdata[1], 32'h0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst_n = 1'b1;
    idle(8);
    issue(1, 1'b0, 32'h4, 4'hF, 32'h0, 32'h21111111, w, c);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hFF22FF44, w, c);
    idle(6);

`ifdef CV32E41P_OBI_MEM_RAND_STALL_EN
    begin
      int lows;
      lows = 0;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'hF;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (gnt[0]) push_exp(0, 32'hDEADBEEF, cyc + LAT_T[0]);
        else        lows++;
      end
      @(posedge clk); #1;
      req[0] = 1'b0;
      checks++;
      if (lows < 200 || lows > 300) begin
        errors++;
        $display("FAIL stall_ratio: gnt low on %0d of 1000 cycles, expected 200..300", lows);
      end
      idle(6);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
